uart_boot_loader: RTL and testbench

UART_BOOT_LOADER -- requirements
Module: uart_boot_loader

---
 rtl/uart_boot_loader_pkg.sv | 25 ++
 rtl/uart_boot_loader.sv | 165 ++++++++++++++++
 tb/tb_uart_boot_loader.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_boot_loader_pkg.sv
// Shared types and default byte constants for the UART boot loader.
// The state list is the single source of truth for the loader FSM encoding.
package uart_boot_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR_HI = 3'd1,
        ST_ADDR_LO = 3'd2,
        ST_LEN     = 3'd3,
        ST_DATA    = 3'd4,
        ST_CSUM    = 3'd5,
        ST_RESP    = 3'd6
    } state_t;

    localparam logic [7:0] DEF_SYNC_BYTE = 8'h55;
    localparam logic [7:0] DEF_ACK_BYTE  = 8'h06;
    localparam logic [7:0] DEF_NAK_BYTE  = 8'h15;

    // Frame-body states, where the inter-byte timeout is armed.
    function automatic logic in_frame_body(input state_t s);
        return (s == ST_ADDR_HI) || (s == ST_ADDR_LO) || (s == ST_LEN) ||
               (s == ST_DATA)    || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/uart_boot_loader.sv
// Serial boot loader: parses SYNC/ADDR/LEN/DATA/CSUM frames from a UART RX FIFO,
// streams data bytes to memory and answers ACK or NAK through the UART TX FIFO.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | hunting for SYNC, non-sync bytes are popped and dropped
// ADDR_HI | waiting for start address high byte
// ADDR_LO | waiting for start address low byte
// LEN     | waiting for length byte (0 means 256)
// DATA    | streaming data bytes to memory
// CSUM    | waiting for checksum byte, verdict latched
// RESP    | pushing ACK/NAK once the TX FIFO has room
module uart_boot_loader
    import uart_boot_loader_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE = DEF_SYNC_BYTE,
    parameter logic [7:0]  ACK_BYTE  = DEF_ACK_BYTE,
    parameter logic [7:0]  NAK_BYTE  = DEF_NAK_BYTE,
    parameter int unsigned TIMEOUT   = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_empty,
    input  logic [7:0]  r_data,
    output logic        rd_uart,
    input  logic        tx_full,
    output logic [7:0]  w_data,
    output logic        wr_uart,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        busy,
    output logic        frame_ok,
    output logic        frame_err
);

    localparam int unsigned       CW        = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]     IDLE_LAST = CW'(TIMEOUT - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [15:0]   r_addr;
    logic [8:0]    r_cnt;
    logic [7:0]    r_csum;
    logic [CW-1:0] r_idle;
    logic          r_resp_ok;
    logic          r_mem_we;
    logic [15:0]   r_mem_addr;
    logic [7:0]    r_mem_wdata;

    logic          w_pop;
    logic          w_push;
    logic          w_expire;
    logic [7:0]    w_csum_sum;

    // RESP never pops, so bytes of the next frame wait in the RX FIFO.
    assign w_pop      = !reset && (r_state != ST_RESP) && !rx_empty;
    assign w_push     = !reset && (r_state == ST_RESP) && !tx_full;
    assign w_expire   = in_frame_body(r_state) && !w_pop && (r_idle == IDLE_LAST);
    assign w_csum_sum = r_csum + r_data;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_pop && (r_data == SYNC_BYTE)) begin
                    w_state_nxt = ST_ADDR_HI;
                end
            end
            ST_ADDR_HI: begin
                if (w_pop) w_state_nxt = ST_ADDR_LO;
            end
            ST_ADDR_LO: begin
                if (w_pop) w_state_nxt = ST_LEN;
            end
            ST_LEN: begin
                if (w_pop) w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (w_pop && (r_cnt == 9'd1)) w_state_nxt = ST_CSUM;
            end
            ST_CSUM: begin
                if (w_pop) w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (w_push) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_expire) begin
            w_state_nxt = ST_RESP;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_addr      <= 16'h0000;
            r_cnt       <= 9'd0;
            r_csum      <= 8'h00;
            r_idle      <= '0;
            r_resp_ok   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 16'h0000;
            r_mem_wdata <= 8'h00;
        end else begin
            r_state  <= w_state_nxt;
            r_mem_we <= 1'b0;

            if (!in_frame_body(r_state) || w_pop) begin
                r_idle <= '0;
            end else begin
                r_idle <= r_idle + CW'(1);
            end

            if (w_pop) begin
                case (r_state)
                    ST_IDLE: begin
                        if (r_data == SYNC_BYTE) r_csum <= 8'h00;
                    end
                    ST_ADDR_HI: begin
                        r_addr[15:8] <= r_data;
                        r_csum       <= w_csum_sum;
                    end
                    ST_ADDR_LO: begin
                        r_addr[7:0] <= r_data;
                        r_csum      <= w_csum_sum;
                    end
                    ST_LEN: begin
                        r_cnt  <= (r_data == 8'h00) ? 9'd256 : {1'b0, r_data};
                        r_csum <= w_csum_sum;
                    end
                    ST_DATA: begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_addr;
                        r_mem_wdata <= r_data;
                        r_addr      <= r_addr + 16'd1;
                        r_cnt       <= r_cnt - 9'd1;
                        r_csum      <= w_csum_sum;
                    end
                    ST_CSUM: begin
                        r_resp_ok <= (w_csum_sum == 8'h00);
                    end
                    default: begin
                    end
                endcase
            end

            if (w_expire) begin
                r_resp_ok <= 1'b0;
            end
        end
    end

    assign rd_uart   = w_pop;
    assign wr_uart   = w_push;
    assign w_data    = w_push ? (r_resp_ok ? ACK_BYTE : NAK_BYTE) : 8'h00;
    assign frame_ok  = w_push && r_resp_ok;
    assign frame_err = w_push && !r_resp_ok;
    assign busy      = (r_state != ST_IDLE);
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader: stimulus queues expected writes and
// responses, an independent monitor pops and compares them as the DUT emits them.
module tb_uart_boot_loader;

    localparam int unsigned TIMEOUT = 100;
    localparam logic [7:0]  ACK     = 8'h06;
    localparam logic [7:0]  NAK     = 8'h15;

    logic        clk;
    logic        reset;
    logic        rx_empty;
    logic [7:0]  r_data;
    logic        rd_uart;
    logic        tx_full;
    logic [7:0]  w_data;
    logic        wr_uart;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        busy;
    logic        frame_ok;
    logic        frame_err;

    uart_boot_loader #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data),
        .rd_uart(rd_uart), .tx_full(tx_full), .w_data(w_data), .wr_uart(wr_uart),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
        .frame_ok(frame_ok), .frame_err(frame_err)
    );

    typedef struct {
        bit          is_resp;
        logic [15:0] addr;
        logic [7:0]  data;
        bit          chk_time;
        bit          chk_rel;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] rx_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         last_pop_cyc = 0;
    int         rel_cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // RX FIFO model: show-ahead head byte, popped on the edge after rd_uart is seen.
    initial begin
        bit pop;
        forever begin
            @(negedge clk);
            pop = rd_uart;
            if (pop) last_pop_cyc = cyc;
            @(posedge clk);
            #1;
            if (pop && rx_q.size() > 0) void'(rx_q.pop_front());
            rx_empty = (rx_q.size() == 0);
            r_data   = rx_empty ? 8'h00 : rx_q[0];
        end
    end

    task automatic handle(input bit is_resp);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_event: got %s with nothing expected (cycle %0d)",
                     is_resp ? "wr_uart" : "mem_we", cyc);
            return;
        end
        e = sb.pop_front();
        chk("event_kind(1=resp)", 32'(is_resp), 32'(e.is_resp));
        if (e.is_resp != is_resp) return;
        if (is_resp) begin
            chk("resp_w_data", 32'(w_data), 32'(e.data));
            chk("frame_ok", 32'(frame_ok), 32'(e.data == ACK));
            chk("frame_err", 32'(frame_err), 32'(e.data == NAK));
            chk("push_with_tx_full", 32'(tx_full), 32'd0);
            // Verdict after TIMEOUT idle cycles, pushed in the following RESP cycle.
            if (e.chk_time) chk("timeout_latency", 32'(cyc - last_pop_cyc), 32'(TIMEOUT + 1));
            if (e.chk_rel)  chk("push_after_release", 32'(cyc), 32'(rel_cyc));
        end else begin
            chk("mem_addr", 32'(mem_addr), 32'(e.addr));
            chk("mem_wdata", 32'(mem_wdata), 32'(e.data));
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (mem_we)  handle(1'b0);
            if (wr_uart) handle(1'b1);
            if ((frame_ok || frame_err) && !wr_uart)
                chk("frame_pulse_without_push", 32'(frame_ok | frame_err), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_resp(input logic [7:0] b, input bit t, input bit r);
        exp_t e;
        e.is_resp = 1'b1; e.addr = 16'h0; e.data = b; e.chk_time = t; e.chk_rel = r;
        sb.push_back(e);
    endtask

    task automatic frame(input logic [15:0] a, input logic [7:0] d[$],
                         input logic [7:0] cs, input logic [7:0] resp,
                         input bit chk_rel, input int gap);
        logic [7:0] bytes[$];
        exp_t e;
        for (int i = 0; i < d.size(); i++) begin
            e.is_resp = 1'b0; e.addr = a + 16'(i); e.data = d[i];
            e.chk_time = 1'b0; e.chk_rel = 1'b0;
            sb.push_back(e);
        end
        exp_resp(resp, 1'b0, chk_rel);
        bytes = '{8'h55, a[15:8], a[7:0], 8'(d.size())};
        foreach (d[i]) bytes.push_back(d[i]);
        bytes.push_back(cs);
        foreach (bytes[i]) begin
            rx_q.push_back(bytes[i]);
            repeat (gap + 1) tick();
        end
    endtask

    task automatic wait_done(input string name, input int bound);
        int n = 0;
        while (!(sb.size() == 0 && rx_q.size() == 0 && !busy) && n < bound) begin
            tick();
            n++;
        end
        if (n >= bound) chk({name, "_completion_timeout"}, 32'(sb.size()), 32'd0);
        repeat (2) tick();
    endtask

    task automatic wait_drained();
        int n = 0;
        while (rx_q.size() != 0 && n < 1000) begin
            tick();
            n++;
        end
    endtask

    initial begin
        logic [7:0] d[$];
        reset = 1'b1; rx_empty = 1'b1; r_data = 8'h00; tx_full = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_rd_uart", 32'(rd_uart), 0);
        chk("rst_wr_uart", 32'(wr_uart), 0);
        chk("rst_w_data", 32'(w_data), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frame_ok", 32'(frame_ok), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        tick();
        reset = 1'b0;
        tick();

        // Good frame, back to back.
        d = '{8'hAA, 8'hBB};
        frame(16'h1234, d, 8'h53, ACK, 1'b0, 0);
        wait_done("good", 200);

        // Bad checksum with gaps between bytes; writes still happen.
        frame(16'h1234, d, 8'h54, NAK, 1'b0, 3);
        wait_done("bad_csum", 300);

        // Address wrap.
        d = '{8'h01, 8'h02};
        frame(16'hFFFF, d, 8'hFD, ACK, 1'b0, 0);
        wait_done("wrap", 200);

        // Garbage bytes dropped while idle, then a stalled frame times out.
        rx_q.push_back(8'h00);
        wait_drained();
        @(negedge clk);
        chk("garbage00_busy", 32'(busy), 0);
        tick();
        rx_q.push_back(8'hFF);
        wait_drained();
        @(negedge clk);
        chk("garbageFF_busy", 32'(busy), 0);
        tick();
        exp_resp(NAK, 1'b1, 1'b0);
        rx_q.push_back(8'h55);
        rx_q.push_back(8'h12);
        wait_done("timeout", 400);

        // TX backpressure for 20 cycles at response time.
        tx_full = 1'b1;
        d = '{8'h5A};
        frame(16'h0100, d, 8'hA4, ACK, 1'b1, 0);
        wait_drained();
        repeat (20) tick();
        tx_full = 1'b0;
        rel_cyc = cyc;
        wait_done("backpressure", 200);

        // LEN=0 means 256 bytes.
        d = {};
        for (int i = 0; i < 256; i++) d.push_back(8'(i));
        frame(16'h1000, d, 8'h70, ACK, 1'b0, 0);
        wait_done("len256", 1000);

        // Reset mid-frame: the write already made stays, no response byte.
        d = '{8'hAA};
        sb.push_back('{1'b0, 16'h2000, 8'hAA, 1'b0, 1'b0});
        foreach (d[i]) begin end
        rx_q.push_back(8'h55); rx_q.push_back(8'h20); rx_q.push_back(8'h00);
        rx_q.push_back(8'h02); rx_q.push_back(8'hAA);
        wait_drained();
        repeat (3) tick();
        chk("write_before_reset", 32'(sb.size()), 0);
        reset = 1'b1;
        rx_q.push_back(8'h55);
        repeat (3) tick();
        @(negedge clk);
        chk("midrst_rx_pending", 32'(rx_empty), 0);
        chk("midrst_rd_uart", 32'(rd_uart), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_mem_addr", 32'(mem_addr), 0);
        chk("midrst_wr_uart", 32'(wr_uart), 0);
        tick();
        rx_q.delete();
        repeat (2) tick();
        reset = 1'b0;
        tick();

        // Recovery after reset.
        d = '{8'h7E};
        frame(16'h0010, d, 8'h71, ACK, 1'b0, 1);
        wait_done("recover", 200);
        repeat (5) tick();
        chk("scoreboard_empty", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
